// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first.
// The line is synchronised before use. Each bit is sampled at its midpoint
// by a down-counter that is timed from the falling edge of the start bit.
// A received byte goes to a one-entry holding register with a valid/ready
// handshake.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned BIT_CYCLES  = CLK_FREQ / BAUD;
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned CNT_W       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             ovr_q;

  logic             rx_meta_q;
  logic             rx_s_q;

  logic             consume;
  logic             cnt_zero;

  assign consume  = valid_q & ready_i;
  assign cnt_zero = (cnt_q == '0);

  // Two-flop synchroniser for the asynchronous line. It resets to idle-high
  // so that reset does not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= serial_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM together with the holding register and the status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (consume) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            cnt_q   <= HALF_RELOAD;
            state_q <= S_START;
          end
        end

        S_START: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (!rx_s_q) begin
            cnt_q   <= BIT_RELOAD;
            idx_q   <= '0;
            state_q <= S_DATA;
          end else begin
            // The line went high again before mid-bit, so treat it as a glitch.
            state_q <= S_IDLE;
          end
        end

        S_DATA: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            shift_q[idx_q] <= rx_s_q;
            cnt_q          <= BIT_RELOAD;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end
        end

        S_STOP: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (rx_s_q) begin
            // A consume in the same cycle frees the register, so the new byte
            // replaces the old one and valid stays high without an overrun.
            if (!valid_q || ready_i) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end else begin
            ferr_q  <= 1'b1;
            state_q <= S_WAIT_HIGH;
          end
        end

        S_WAIT_HIGH: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx, run at a reduced bit time (16 clocks per bit).
module tb_uart_rx;

  localparam int BIT  = 16;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_rx;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;

  int n_cmp = 0;
  int n_err = 0;

  // Counts and received bytes, recorded by the monitor.
  int       n_rise = 0;
  int       n_ferr = 0;
  int       n_ovr  = 0;
  logic     valid_prev = 1'b0;
  time      last_rise_t = 0;
  time      lat_start = 0;
  logic [7:0] got_q[$];

  uart_rx #(.CLK_FREQ(160), .BAUD(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .serial_rx   (serial_rx),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_o && !valid_prev) begin
      n_rise++;
      last_rise_t = $time;
    end
    valid_prev = valid_o;
    if (frame_err_o) n_ferr++;
    if (overrun_o) n_ovr++;
    if (valid_o && ready_i) got_q.push_back(data_o);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Call this at a negedge. It returns at a negedge with the stop level still on the line.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    serial_rx = 1'b0;
    lat_start = $time;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    serial_rx = stop;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic idle(input int n);
    serial_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_byte(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    b = 8'hxx;
    if (got_q.size() != 0) b = got_q.pop_front();
    check(tag, {24'd0, b}, {24'd0, exp});
  endtask

  initial begin
    int r0, f0, o0, lat;
    rst       = 1'b1;
    serial_rx = 1'b1;
    ready_i   = 1'b1;
    #1;
    check("rst_data", {24'd0, data_o}, 32'h00);
    check("rst_valid", {31'd0, valid_o}, 0);
    check("rst_ferr", {31'd0, frame_err_o}, 0);
    check("rst_ovr", {31'd0, overrun_o}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(10);

    // Frame 0x34 with ready held high. Also measures latency from the start edge.
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h34, 1'b1);
    idle(20);
    check("f34_rises", n_rise - r0, 1);
    check_byte("f34_byte", 8'h34);
    check("f34_ferr", n_ferr - f0, 0);
    check("f34_ovr", n_ovr - o0, 0);
    lat = int'((last_rise_t - lat_start) / 10);
    check("f34_latency_in_range", {31'd0, (lat >= 2 + HALF + 9*BIT - 1) && (lat <= 2 + HALF + 9*BIT + 1)}, 1);

    // Short low glitch, shorter than half a bit.
    r0 = n_rise; f0 = n_ferr;
    serial_rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    check("glitch_rises", n_rise - r0, 0);
    check("glitch_ferr", n_ferr - f0, 0);

    // Frame 0xA5 with a bad stop bit, line held low for 3 bit times, then 0x5A.
    r0 = n_rise; f0 = n_ferr;
    send_frame(8'hA5, 1'b0);
    repeat (3*BIT) @(negedge clk);
    idle(30);
    check("ferr_pulses", n_ferr - f0, 1);
    check("ferr_rises", n_rise - r0, 0);
    send_frame(8'h5A, 1'b1);
    idle(20);
    check_byte("after_ferr_byte", 8'h5A);
    check("after_ferr_rises", n_rise - r0, 1);

    // Overrun: with ready low, frame 0x34 is held and frame 0x56 is dropped.
    ready_i = 1'b0;
    r0 = n_rise; o0 = n_ovr;
    send_frame(8'h34, 1'b1);
    send_frame(8'h56, 1'b1);
    idle(20);
    check("ovr_data", {24'd0, data_o}, 32'h34);
    check("ovr_valid", {31'd0, valid_o}, 1);
    check("ovr_pulses", n_ovr - o0, 1);
    check("ovr_rises", n_rise - r0, 1);
    @(posedge clk);
    #1 ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_drop", {31'd0, valid_o}, 0);
    check_byte("ovr_consumed", 8'h34);
    idle(10);

    // Reset during bit 4 of a 0xFF frame, then frame 0x12.
    r0 = n_rise; f0 = n_ferr;
    serial_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    serial_rx = 1'b1;
    repeat (4*BIT + HALF) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(4*BIT);
    check("abort_rises", n_rise - r0, 0);
    send_frame(8'h12, 1'b1);
    idle(20);
    check("abort_then_rises", n_rise - r0, 1);
    check_byte("abort_then_byte", 8'h12);
    check("abort_ferr", n_ferr - f0, 0);

    // Three frames back to back with no extra idle time between them.
    r0 = n_rise;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    idle(20);
    check("b2b_rises", n_rise - r0, 3);
    check_byte("b2b_0", 8'h00);
    check_byte("b2b_1", 8'hFF);
    check_byte("b2b_2", 8'h81);
    check("b2b_leftover", got_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
